// File: rtl/pc_rx_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_rx_pkg : header bytes, FSM encoding and info-word packing
// Rev 1.0
// ------------------------------------------------------------------
package pc_rx_pkg;

  localparam logic [7:0] HDR0     = 8'hEB;
  localparam logic [7:0] HDR1     = 8'h90;
  localparam logic [7:0] CMD_TEST = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_LENH = 3'd2,
    ST_LENL = 3'd3,
    ST_CMD  = 3'd4,
    ST_DATA = 3'd5,
    ST_CKS  = 3'd6,
    ST_SKIP = 3'd7
  } state_t;

  localparam int INFO_W         = 72;
  localparam int INFO_START_LSB = 60;
  localparam int INFO_LEN_LSB   = 48;
  localparam int INFO_CMD_LSB   = 32;
  localparam int INFO_SEQ_LSB   = 16;
  localparam int INFO_CKS_LSB   = 8;

  function automatic logic [INFO_W-1:0] pack_info(
    input logic [11:0] start,
    input logic [11:0] len,
    input logic [7:0]  cmd,
    input logic [15:0] seq,
    input logic [7:0]  cks
  );
    logic [INFO_W-1:0] w;
    w = '0;
    w[INFO_START_LSB +: 12] = start;
    w[INFO_LEN_LSB   +: 12] = len;
    w[INFO_CMD_LSB   +: 8]  = cmd;
    w[INFO_SEQ_LSB   +: 16] = seq;
    w[INFO_CKS_LSB   +: 8]  = cks;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_rx_byte_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_rx_byte_timer : inter-byte idle counter with one-cycle expire
// Rev 1.0
// ------------------------------------------------------------------
module pc_rx_byte_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires once the full idle budget has elapsed; a byte in this cycle is lost.
  assign expire_o = en_i && (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/pc_rx_frame_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_rx_frame_writer : parses PC link frames into the BRAM ring and info FIFO
// Rev 1.0
// ------------------------------------------------------------------
module pc_rx_frame_writer
  import pc_rx_pkg::*;
#(
  parameter int U_DLY       = 1,
  parameter int MAX_LEN     = 1024,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        fdram_wr_en,
  output logic [11:0] fdram_wr_addr,
  output logic [7:0]  fdram_wr_data,
  input  logic [11:0] fdram_rd_ptr,
  output logic        fififo_wr_en,
  output logic [71:0] fififo_wr_data,
  input  logic        fififo_full,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cks_cnt,
  output logic [15:0] err_drop_cnt,
  output logic [15:0] err_tmo_cnt
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  state_t      state_q;
  logic [11:0] wr_ptr_q;
  logic [11:0] idx_q;
  logic [11:0] len_q;
  logic [15:0] seq_q;
  logic [15:0] skip_q;
  logic [7:0]  len_h_q;
  logic [7:0]  cmd_q;
  logic [7:0]  sum_q;

  logic        w_idle;
  logic        w_expire;
  logic        w_byte;
  logic        w_too_big;
  logic [15:0] w_len;
  logic [11:0] w_space;
  logic        w_unused_udly;

  assign w_unused_udly = (U_DLY != 0);

  assign w_idle    = (state_q == ST_IDLE);
  assign w_byte    = rx_valid && !w_expire;
  assign w_len     = {len_h_q, rx_data};
  // One slot is always kept free so a full ring never looks empty.
  assign w_space   = fdram_rd_ptr - wr_ptr_q - 12'd1;
  assign w_too_big = (w_len > MAX_LEN_C) || (w_len > {4'd0, w_space});

  pc_rx_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .clear_i  (rx_valid || w_idle),
    .en_i     (!w_idle),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      idx_q          <= '0;
      len_q          <= '0;
      seq_q          <= '0;
      skip_q         <= '0;
      len_h_q        <= '0;
      cmd_q          <= '0;
      sum_q          <= '0;
      fdram_wr_en    <= 1'b0;
      fdram_wr_addr  <= '0;
      fdram_wr_data  <= '0;
      fififo_wr_en   <= 1'b0;
      fififo_wr_data <= '0;
      frame_cnt      <= '0;
      err_cks_cnt    <= '0;
      err_drop_cnt   <= '0;
      err_tmo_cnt    <= '0;
    end else begin
      fdram_wr_en  <= 1'b0;
      fififo_wr_en <= 1'b0;
      if (w_expire) begin
        state_q     <= ST_IDLE;
        err_tmo_cnt <= sat_inc(err_tmo_cnt);
      end else if (w_byte) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == HDR0) state_q <= ST_HDR2;
          end
          ST_HDR2: begin
            if (rx_data == HDR1)      state_q <= ST_LENH;
            else if (rx_data != HDR0) state_q <= ST_IDLE;
          end
          ST_LENH: begin
            len_h_q <= rx_data;
            sum_q   <= rx_data;
            state_q <= ST_LENL;
          end
          ST_LENL: begin
            sum_q   <= sum_q + rx_data;
            len_q   <= w_len[11:0];
            skip_q  <= w_len;
            state_q <= w_too_big ? ST_SKIP : ST_CMD;
          end
          ST_CMD: begin
            cmd_q   <= rx_data;
            sum_q   <= sum_q + rx_data;
            idx_q   <= '0;
            state_q <= (len_q == 12'd0) ? ST_CKS : ST_DATA;
          end
          ST_DATA: begin
            fdram_wr_en   <= 1'b1;
            fdram_wr_addr <= wr_ptr_q + idx_q;
            fdram_wr_data <= rx_data;
            sum_q         <= sum_q + rx_data;
            idx_q         <= idx_q + 12'd1;
            if (idx_q == len_q - 12'd1) state_q <= ST_CKS;
          end
          ST_CKS: begin
            state_q <= ST_IDLE;
            if (rx_data != sum_q) begin
              err_cks_cnt <= sat_inc(err_cks_cnt);
            end else if (fififo_full) begin
              err_drop_cnt <= sat_inc(err_drop_cnt);
            end else begin
              fififo_wr_en   <= 1'b1;
              fififo_wr_data <= pack_info(wr_ptr_q, len_q, cmd_q, seq_q, rx_data);
              wr_ptr_q       <= wr_ptr_q + len_q;
              seq_q          <= seq_q + 16'd1;
              frame_cnt      <= sat_inc(frame_cnt);
            end
          end
          ST_SKIP: begin
            // skip_q holds LEN, so LEN+1 bytes (CMD..last payload) are swallowed.
            if (skip_q == 16'd0) begin
              state_q      <= ST_IDLE;
              err_drop_cnt <= sat_inc(err_drop_cnt);
            end else begin
              skip_q <= skip_q - 16'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_rx_frame_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_pc_rx_frame_writer : directed + random frames against a ring/FIFO model
// Rev 1.0
// ------------------------------------------------------------------
module tb_pc_rx_frame_writer;
  import pc_rx_pkg::*;

  localparam int MAX_LEN = 1024;
  localparam int TMO     = 200;

  logic        clk_sys;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fdram_wr_en;
  logic [11:0] fdram_wr_addr;
  logic [7:0]  fdram_wr_data;
  logic [11:0] fdram_rd_ptr;
  logic        fififo_wr_en;
  logic [71:0] fififo_wr_data;
  logic        fififo_full;
  logic [15:0] frame_cnt;
  logic [15:0] err_cks_cnt;
  logic [15:0] err_drop_cnt;
  logic [15:0] err_tmo_cnt;

  pc_rx_frame_writer #(
    .U_DLY       (1),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .fdram_wr_en    (fdram_wr_en),
    .fdram_wr_addr  (fdram_wr_addr),
    .fdram_wr_data  (fdram_wr_data),
    .fdram_rd_ptr   (fdram_rd_ptr),
    .fififo_wr_en   (fififo_wr_en),
    .fififo_wr_data (fififo_wr_data),
    .fififo_full    (fififo_full),
    .frame_cnt      (frame_cnt),
    .err_cks_cnt    (err_cks_cnt),
    .err_drop_cnt   (err_drop_cnt),
    .err_tmo_cnt    (err_tmo_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed side: BRAM image and FIFO words, captured on the falling edge.
  logic [7:0]  dut_mem [0:4095];
  logic [71:0] fifo_q [$];
  int          wr_count = 0;

  always @(negedge clk_sys) begin
    if (fdram_wr_en) begin
      dut_mem[fdram_wr_addr] = fdram_wr_data;
      wr_count++;
    end
    if (fififo_wr_en) fifo_q.push_back(fififo_wr_data);
  end

  // Reference model state.
  logic [7:0]  pay [0:4095];
  logic [11:0] m_wp;
  logic [15:0] m_seq, m_frames, m_cks, m_drop, m_tmo;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "/frame_cnt"},    72'(frame_cnt),    72'(m_frames));
    check({tag, "/err_cks_cnt"},  72'(err_cks_cnt),  72'(m_cks));
    check({tag, "/err_drop_cnt"}, 72'(err_drop_cnt), 72'(m_drop));
    check({tag, "/err_tmo_cnt"},  72'(err_tmo_cnt),  72'(m_tmo));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/fdram_wr_en"},    72'(fdram_wr_en),    72'(0));
    check({tag, "/fdram_wr_addr"},  72'(fdram_wr_addr),  72'(0));
    check({tag, "/fdram_wr_data"},  72'(fdram_wr_data),  72'(0));
    check({tag, "/fififo_wr_en"},   72'(fififo_wr_en),   72'(0));
    check({tag, "/fififo_wr_data"}, fififo_wr_data,      72'(0));
    check({tag, "/frame_cnt"},      72'(frame_cnt),      72'(0));
    check({tag, "/err_cks_cnt"},    72'(err_cks_cnt),    72'(0));
    check({tag, "/err_drop_cnt"},   72'(err_drop_cnt),   72'(0));
    check({tag, "/err_tmo_cnt"},    72'(err_tmo_cnt),    72'(0));
  endtask

  task automatic model_reset();
    m_wp = '0; m_seq = '0; m_frames = '0; m_cks = '0; m_drop = '0; m_tmo = '0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_sys);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      rx_valid = 1'b0;
    end
  endtask

  task automatic fill_pay(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  // Sends one frame (payload from pay[]) and checks the outcome the
  // ring/FIFO rules predict. gap>0 inserts idle cycles after payload byte 1.
  task automatic send_frame(input string tag, input int len, input logic [7:0] cmd,
                            input bit bad, input bit full, input int gap);
    logic [11:0] space;
    logic [11:0] start;
    logic [15:0] l16;
    logic [7:0]  cks;
    logic [7:0]  filler;
    bit          skip;
    bit          commit;
    int          w0, f0, bad_bytes;
    l16    = 16'(len);
    space  = fdram_rd_ptr - m_wp - 12'd1;
    skip   = (len > MAX_LEN) || (len > int'(space));
    start  = m_wp;
    w0     = wr_count;
    f0     = fifo_q.size();
    commit = 1'b0;
    cks    = l16[15:8] + l16[7:0] + cmd;
    for (int i = 0; i < len; i++) cks = cks + pay[i];

    send(HDR0); send(HDR1); send(l16[15:8]); send(l16[7:0]);
    if (skip) begin
      for (int i = 0; i <= len; i++) begin
        filler = 8'($urandom_range(0, 255));
        if (filler == HDR0) filler = 8'h00;
        send(filler);
      end
      idle(3);
      m_drop = sat(m_drop);
    end else begin
      send(cmd);
      for (int i = 0; i < len; i++) begin
        send(pay[i]);
        if (i == 1 && gap > 0) idle(gap);
      end
      fififo_full = full;
      send(bad ? (cks ^ 8'hFF) : cks);
      commit = !bad && !full;
      @(negedge clk_sys);
      rx_valid = 1'b0;
      check({tag, "/fifo_wr_en_pulse"}, 72'(fififo_wr_en), 72'(commit));
      @(negedge clk_sys);
      check({tag, "/fifo_wr_en_drop"}, 72'(fififo_wr_en), 72'(0));
      fififo_full = 1'b0;
      idle(1);
      if (bad)       m_cks  = sat(m_cks);
      else if (full) m_drop = sat(m_drop);
    end

    check({tag, "/bram_writes"}, 72'(wr_count - w0), 72'(skip ? 0 : len));
    check({tag, "/fifo_writes"}, 72'(fifo_q.size() - f0), 72'(commit));
    if (commit && fifo_q.size() > f0) begin
      check({tag, "/info_word"}, fifo_q[f0], {start, l16[11:0], 8'h00, cmd, m_seq, cks, 8'h00});
      bad_bytes = 0;
      for (int i = 0; i < len; i++)
        if (dut_mem[12'(int'(start) + i)] !== pay[i]) bad_bytes++;
      check({tag, "/bram_data"}, 72'(bad_bytes), 72'(0));
    end
    if (commit) begin
      m_wp     = start + l16[11:0];
      m_seq    = m_seq + 16'd1;
      m_frames = sat(m_frames);
    end
    check_counters(tag);
  endtask

  initial begin
    int          w0, f0, len;
    logic [11:0] need;
    logic [71:0] word;
    logic [11:0] fld;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; fdram_rd_ptr = '0; fififo_full = 1'b0;
    model_reset();
    idle(3);
    check_all_zero("reset");
    @(negedge clk_sys);
    rst = 1'b0;
    idle(2);

    // Checksum failure, then the same frame good: must start at 000.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame("bad_cks", 3, CMD_TEST, 1'b1, 1'b0, 0);
    send_frame("frame_a", 3, CMD_TEST, 1'b0, 1'b0, 0);
    word = (fifo_q.size() > 0) ? fifo_q[fifo_q.size()-1] : '0;
    check("frame_a/info_const", word, 72'h000_003_00_80_0000_E9_00);

    for (int k = 0; k < 5; k++) begin
      fdram_rd_ptr = m_wp;
      len = $urandom_range(0, 200);
      fill_pay(len);
      send_frame("random", len, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0, 0);
    end

    // Advance the ring so the next frame straddles 0xFFF -> 0x000.
    while (m_wp != 12'hFFE) begin
      fdram_rd_ptr = m_wp;
      need = 12'hFFE - m_wp;
      len  = (need > 12'd1000) ? 1000 : int'(need);
      fill_pay(len);
      send_frame("fill", len, CMD_TEST, 1'b0, 1'b0, 0);
    end
    fdram_rd_ptr = m_wp;
    fill_pay(4);
    send_frame("wrap", 4, CMD_TEST, 1'b0, 1'b0, 0);
    word = (fifo_q.size() > 0) ? fifo_q[fifo_q.size()-1] : '0;
    fld  = word[71:60];
    check("wrap/start_field", 72'(fld), 72'(12'hFFE));

    fdram_rd_ptr = m_wp;
    send_frame("oversize", 16'h0500, CMD_TEST, 1'b0, 1'b0, 0);
    fill_pay(7);
    send_frame("after_oversize", 7, CMD_TEST, 1'b0, 1'b0, 0);

    fdram_rd_ptr = m_wp + 12'd2;
    send_frame("no_space", $urandom_range(2, 40), CMD_TEST, 1'b0, 1'b0, 0);
    fill_pay(1);
    send_frame("space_exact", 1, CMD_TEST, 1'b0, 1'b0, 0);

    fdram_rd_ptr = m_wp;
    send(HDR0);
    fill_pay(6);
    send_frame("resync", 6, 8'h42, 1'b0, 1'b0, 0);

    fill_pay(5);
    send_frame("gap_ok", 5, CMD_TEST, 1'b0, 1'b0, TMO - 1);

    // Stall for the full budget; the EB landing on the expiry cycle is lost,
    // so the rest of that would-be frame is just noise in IDLE.
    fdram_rd_ptr = m_wp;
    w0 = wr_count;
    f0 = fifo_q.size();
    send(HDR0); send(HDR1); send(8'h00); send(8'h05); send(CMD_TEST); send(8'hA1); send(8'hA2);
    idle(TMO);
    send(HDR0); send(HDR1); send(8'h00); send(8'h01); send(CMD_TEST); send(8'h10); send(8'h91);
    idle(3);
    m_tmo = sat(m_tmo);
    check("timeout/bram_writes", 72'(wr_count - w0), 72'(2));
    check("timeout/fifo_writes", 72'(fifo_q.size() - f0), 72'(0));
    check_counters("timeout");
    fill_pay(3);
    send_frame("after_timeout", 3, CMD_TEST, 1'b0, 1'b0, 0);

    fill_pay(8);
    send_frame("fifo_full", 8, CMD_TEST, 1'b0, 1'b1, 0);
    fill_pay(4);
    send_frame("after_full", 4, CMD_TEST, 1'b0, 1'b0, 0);

    // Reset in the middle of DATA while a write strobe is live.
    fdram_rd_ptr = m_wp;
    send(HDR0); send(HDR1); send(8'h00); send(8'h08); send(CMD_TEST);
    send(8'h01); send(8'h02); send(8'h03);
    @(posedge clk_sys);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    rx_valid = 1'b0;
    idle(2);
    @(negedge clk_sys);
    rst = 1'b0;
    model_reset();
    fdram_rd_ptr = '0;
    fill_pay(5);
    send_frame("post_reset", 5, CMD_TEST, 1'b0, 1'b0, 0);
    word = (fifo_q.size() > 0) ? fifo_q[fifo_q.size()-1] : '1;
    fld  = word[71:60];
    check("post_reset/start_field", 72'(fld), 72'(12'h000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_rx_frame_writer.md
Name: pc_rx_frame_writer

Overview:
Write-side front end of the PC receive path.
- Parses the byte stream arriving from the PC link into frames.
- Stores each frame's payload bytes into the frame data BRAM, which is a 4096-byte ring.
- On a good frame, pushes one 72-bit frame-info word into the frame info FIFO, where the downstream frame consumer pops and decodes it.
- Bad, oversized, timed-out or unstorable frames are rolled back and counted.

Parameters:
U_DLY, 1, simulation delay on register assignments.
MAX_LEN, 1024, largest accepted payload length in bytes; must be ≤ 4095.
TIMEOUT_CYC, 100000, idle clk_sys cycles allowed between bytes inside a frame before it is aborted.

Ports:
clk_sys  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe qualifying rx_data; at most one byte per cycle, no backpressure.
fdram_wr_en  out  1  BRAM write strobe.
fdram_wr_addr  out  12  BRAM write address.
fdram_wr_data  out  8  BRAM write data.
fdram_rd_ptr  in  12  consumer's oldest unreleased BRAM address; used for the free-space check.
fififo_wr_en  out  1  info FIFO write strobe.
fififo_wr_data  out  72  frame-info word.
fififo_full  in  1  info FIFO full.
frame_cnt  out  16  good frames committed, saturating.
err_cks_cnt  out  16  checksum-fail frames, saturating.
err_drop_cnt  out  16  frames dropped (too long, no BRAM space, FIFO full), saturating.
err_tmo_cnt  out  16  frames aborted by timeout, saturating.

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_ptr=0, frame seq=0, timer=0.
- Frame format: EB 90 LEN_H LEN_L CMD PAYLOAD[LEN] CKS.
  - LEN = {LEN_H,LEN_L}, counting payload bytes only.
  - CKS = 8-bit modulo sum of LEN_H through the last payload byte (CMD included).
- States and transitions (each step consumes one rx_valid byte):
  - IDLE: byte=EB → HDR2.
  - HDR2: byte=90 → LENH; byte=EB → stay in HDR2; anything else → IDLE.
  - LENH → LENL.
  - LENL: if LEN>MAX_LEN, or LEN > space → SKIP; otherwise → CMD.
    - space = (fdram_rd_ptr − wr_ptr − 1) mod 4096.
  - CMD: latch CMD; LEN=0 → CKS, else → DATA.
  - DATA: write each byte to wr_ptr+idx (12-bit wrap); after LEN bytes → CKS.
  - CKS → IDLE, with commit or reject as described below.
  - SKIP: consume LEN+1 bytes with no BRAM writes; err_drop_cnt++; → IDLE.
- BRAM writes: fdram_wr_en is asserted in the cycle after the accepted DATA byte, with matching address and data. Address arithmetic wraps modulo 4096 (0xFFF → 0x000).
- Commit (CKS byte matches and fififo_full=0):
  - fififo_wr_en high for exactly 1 cycle, in the cycle after the CKS byte.
  - wr_ptr advances to start+LEN, mod 4096.
  - seq++ (wrapping); frame_cnt++.
- Reject:
  - Checksum mismatch → err_cks_cnt++.
  - Checksum matches but fififo_full=1 → err_drop_cnt++.
  - In both cases wr_ptr is unchanged, so the bytes written are logically discarded and later overwritten.
- Info word layout:
  - [71:60] start address.
  - [59:48] LEN[11:0].
  - [47:40] 0.
  - [39:32] CMD (0x80 is the test command).
  - [31:16] seq.
  - [15:8] CKS.
  - [7:0] 0.
- Timeout: the timer clears on every rx_valid and in IDLE. Otherwise it increments; on reaching TIMEOUT_CYC the state returns to IDLE, err_tmo_cnt++, and wr_ptr is unchanged.
- A byte arriving in the same cycle the timeout fires is ignored.
- All counters saturate at 0xFFFF.
- Asserting rst mid-frame discards the frame, clears wr_ptr, and drops fififo_wr_en at once. The consumer must be reset together with this block.

Decomposition:
- Package pc_rx_pkg holds:
  - header constants HDR0=8'hEB, HDR1=8'h90;
  - the state enum;
  - info-word field bit positions;
  - CMD_TEST=8'h80.
- One sub-module, pc_rx_byte_timer: the inter-byte timeout counter, with clear/enable inputs and an expire pulse output, parameterised by TIMEOUT_CYC.

Test Plan:
- Frame EB 90 00 03 80 11 22 33 CKS=E9, fdram_rd_ptr=0 → BRAM[0..2]=11,22,33; one FIFO word with [71:60]=000, [59:48]=003, [39:32]=80, seq=0; frame_cnt=1.
- Same frame with CKS=00 → no FIFO write; err_cks_cnt=1; the next good frame starts at address 000.
- wr_ptr preset to FFE by prior frames, LEN=4 → writes land at FFE, FFF, 000, 001; the info word start field is FFE; wr_ptr becomes 002.
- LEN=0x0500 (>MAX_LEN), or LEN > space with fdram_rd_ptr=wr_ptr+2 → no BRAM writes; LEN+1 bytes skipped; err_drop_cnt++; an immediately following good frame is accepted.
- Stream EB EB 90 ... (good frame) → frame accepted (header resync). Frame halted after 2 payload bytes for TIMEOUT_CYC cycles → err_tmo_cnt=1, no FIFO write, state back in IDLE.
- fififo_full=1 at the CKS byte of a valid frame → err_drop_cnt++, wr_ptr unchanged; assert rst mid-DATA → all outputs 0 and the next frame is written from address 000.
